// File: rtl/sr_latch_driver_if.sv
// Command and feedback signals between the SR latch driver and its environment.
// The slave modport is the driver; the master side issues requests and returns latch feedback.
interface sr_latch_driver_if;
  logic set_req;
  logic clr_req;
  logic q_fb;
  logic qbar_fb;
  logic s_out;
  logic r_out;
  logic busy;
  logic done;
  logic err;
  logic conflict;

  modport master (
    output set_req,
    output clr_req,
    output q_fb,
    output qbar_fb,
    input  s_out,
    input  r_out,
    input  busy,
    input  done,
    input  err,
    input  conflict
  );

  modport slave (
    input  set_req,
    input  clr_req,
    input  q_fb,
    input  qbar_fb,
    output s_out,
    output r_out,
    output busy,
    output done,
    output err,
    output conflict
  );
endinterface

// File: rtl/sr_latch_driver.sv
// Turns single-cycle set/clear requests into fixed-width S/R pulses with a dead-time gap,
// then checks the latch feedback and reports done/err.
module sr_latch_driver #(
  parameter int unsigned PULSE_W = 4,
  parameter int unsigned GAP_W   = 2
) (
  input logic              clk,
  input logic              rst,
  sr_latch_driver_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StPulse, StGap, StReport} state_e;
  typedef enum logic {CmdSet, CmdClr} cmd_e;

  // Counters are loaded with width-1 so the state ends on the cycle the counter reads zero.
  localparam logic [7:0] PulseLoad = 8'(PULSE_W - 1);
  localparam logic [7:0] GapLoad   = 8'(GAP_W - 1);

  state_e     state_q;
  cmd_e       cmd_q;
  logic [7:0] cnt_q;
  logic       s_out_q;
  logic       r_out_q;
  logic       busy_q;
  logic       done_q;
  logic       err_q;
  logic       conflict_q;

  logic fb_mismatch;
  logic req_set_only;
  logic req_clr_only;
  logic req_both;

  always_comb begin
    if (cmd_q == CmdSet) begin
      fb_mismatch = !(bus.q_fb && !bus.qbar_fb);
    end else begin
      fb_mismatch = !(!bus.q_fb && bus.qbar_fb);
    end
  end

  assign req_set_only = bus.set_req && !bus.clr_req;
  assign req_clr_only = bus.clr_req && !bus.set_req;
  assign req_both     = bus.set_req && bus.clr_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cmd_q      <= CmdSet;
      cnt_q      <= 8'd0;
      s_out_q    <= 1'b0;
      r_out_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      conflict_q <= 1'b0;

      unique case (state_q)
        // REPORT accepts requests exactly like IDLE so commands can run back to back.
        StIdle, StReport: begin
          state_q <= StIdle;
          s_out_q <= 1'b0;
          r_out_q <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= 8'd0;
          if (req_set_only || req_clr_only) begin
            state_q <= StPulse;
            cmd_q   <= req_set_only ? CmdSet : CmdClr;
            cnt_q   <= PulseLoad;
            s_out_q <= req_set_only;
            r_out_q <= req_clr_only;
            busy_q  <= 1'b1;
          end else if (req_both) begin
            conflict_q <= 1'b1;
          end
        end

        StPulse: begin
          if (cnt_q == 8'd0) begin
            state_q <= StGap;
            cnt_q   <= GapLoad;
            s_out_q <= 1'b0;
            r_out_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end

        StGap: begin
          if (cnt_q == 8'd0) begin
            state_q <= StReport;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= fb_mismatch;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
      endcase
    end
  end

  assign bus.s_out    = s_out_q;
  assign bus.r_out    = r_out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.conflict = conflict_q;

endmodule
